// File: rtl/mac_package.sv
// Shared types and constants for the MAC engine and its iteration sequencer.
//   state_fsm_t    : sequencer FSM state encoding
//   ctrl_engine_t  : sequencer -> engine control bundle
//   flags_engine_t : engine -> sequencer status bundle
//   ctrl_seq_t     : job configuration latched by the sequencer at start
package mac_package;

  localparam int unsigned MAC_CNT_LEN = 1024;
  localparam int unsigned MAC_LEN_W   = $clog2(MAC_CNT_LEN) + 1;
  localparam int unsigned MAC_ITER_W  = 32;  // widest supported iteration count

  typedef enum logic [2:0] {
    FSM_IDLE      = 3'd0,
    FSM_START     = 3'd1,
    FSM_COMPUTE   = 3'd2,
    FSM_WAIT      = 3'd3,
    FSM_UPDATEIDX = 3'd4,
    FSM_TERMINATE = 3'd5
  } state_fsm_t;

  typedef struct packed {
    logic                 clear;
    logic                 enable;
    logic                 start;
    logic                 simple_mul;
    logic [4:0]           shift;
    logic [MAC_LEN_W-1:0] len;
  } ctrl_engine_t;

  typedef struct packed {
    logic acc_done;
  } flags_engine_t;

  typedef struct packed {
    logic [MAC_ITER_W-1:0] nb_iter;
    logic [MAC_LEN_W-1:0]  len;
    logic [4:0]            shift;
    logic                  simple_mul;
  } ctrl_seq_t;

endpackage

// File: rtl/mac_iter_addrgen.sv
// Iteration counter and A/B/C/D address generator.
//   load_i : capture bases and stride, zero the counter
//   step_i : A/B += stride, C/D += 4 (mod 2^32), counter += 1
//   clear_i: synchronous zero of everything, wins over load/step
// Outputs hold their value between strobes.
module mac_iter_addrgen #(
  parameter int unsigned NB_ITER_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [31:0]          base_a_i,
  input  logic [31:0]          base_b_i,
  input  logic [31:0]          base_c_i,
  input  logic [31:0]          base_d_i,
  input  logic [31:0]          stride_i,
  output logic [31:0]          addr_a_o,
  output logic [31:0]          addr_b_o,
  output logic [31:0]          addr_c_o,
  output logic [31:0]          addr_d_o,
  output logic [NB_ITER_W-1:0] iter_cnt_o
);

  logic [31:0] stride_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_a_o   <= '0;
      addr_b_o   <= '0;
      addr_c_o   <= '0;
      addr_d_o   <= '0;
      stride_q   <= '0;
      iter_cnt_o <= '0;
    end else if (clear_i) begin
      addr_a_o   <= '0;
      addr_b_o   <= '0;
      addr_c_o   <= '0;
      addr_d_o   <= '0;
      stride_q   <= '0;
      iter_cnt_o <= '0;
    end else if (load_i) begin
      addr_a_o   <= base_a_i;
      addr_b_o   <= base_b_i;
      addr_c_o   <= base_c_i;
      addr_d_o   <= base_d_i;
      stride_q   <= stride_i;
      iter_cnt_o <= '0;
    end else if (step_i) begin
      // C and D hold one 32-bit result word per scalar product
      addr_a_o   <= addr_a_o + stride_q;
      addr_b_o   <= addr_b_o + stride_q;
      addr_c_o   <= addr_c_o + 32'd4;
      addr_d_o   <= addr_d_o + 32'd4;
      iter_cnt_o <= iter_cnt_o + NB_ITER_W'(1);
    end
  end

endmodule

// File: rtl/mac_iter_sequencer.sv
// Job sequencer for the MAC engine: runs nb_iter scalar products of length
// len_iter, each one clear -> request/start -> accumulate -> drain to D sink.
//   clk_i/rst_i/clear_i      : clock, async reset, sync soft clear
//   start_i + job config     : nb_iter, len_iter, shift, simple_mul, bases, stride
//   src_ready_i / src_req_o  : streamer handshake (request is a 1-cycle pulse)
//   addr_[abcd]_o            : addresses of the current iteration
//   ctrl_engine_o / flags_engine_i : engine control and acc_done status
//   sink_done_i              : D sink finished writing the current result
//   busy_o, done_o, state_o  : status
module mac_iter_sequencer
  import mac_package::*;
#(
  parameter int unsigned CNT_LEN   = MAC_CNT_LEN,
  parameter int unsigned NB_ITER_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       start_i,
  input  logic [NB_ITER_W-1:0]       nb_iter_i,
  input  logic [$clog2(CNT_LEN):0]   len_iter_i,
  input  logic [4:0]                 shift_i,
  input  logic                       simple_mul_i,
  input  logic [31:0]                base_a_i,
  input  logic [31:0]                base_b_i,
  input  logic [31:0]                base_c_i,
  input  logic [31:0]                base_d_i,
  input  logic [31:0]                stride_i,
  input  logic                       src_ready_i,
  output logic                       src_req_o,
  output logic [31:0]                addr_a_o,
  output logic [31:0]                addr_b_o,
  output logic [31:0]                addr_c_o,
  output logic [31:0]                addr_d_o,
  output ctrl_engine_t               ctrl_engine_o,
  input  flags_engine_t              flags_engine_i,
  input  logic                       sink_done_i,
  output logic                       busy_o,
  output logic                       done_o,
  output state_fsm_t                 state_o
);

  state_fsm_t           state_q, state_d;
  ctrl_seq_t            cfg_q;
  logic                 first_q;      // first cycle of FSM_START (engine clear)
  logic                 sink_seen_q;  // sink_done that arrived during COMPUTE
  logic                 zero_done_q;  // empty job: done pulse one cycle after start
  logic                 load, step, req, eng_clear, zero_job;
  logic [NB_ITER_W-1:0] iter_cnt, iter_nxt;

  assign zero_job = (nb_iter_i == '0) || (len_iter_i == '0);
  assign iter_nxt = iter_cnt + NB_ITER_W'(1);

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    step      = 1'b0;
    req       = 1'b0;
    eng_clear = 1'b0;
    unique case (state_q)
      FSM_IDLE: begin
        if (start_i) begin
          load = 1'b1;
          if (!zero_job) state_d = FSM_START;
        end
      end
      FSM_START: begin
        if (first_q) begin
          eng_clear = 1'b1;
        end else if (src_ready_i) begin
          req     = 1'b1;
          state_d = FSM_COMPUTE;
        end
      end
      FSM_COMPUTE: if (flags_engine_i.acc_done) state_d = FSM_WAIT;
      FSM_WAIT:    if (sink_done_i || sink_seen_q) state_d = FSM_UPDATEIDX;
      FSM_UPDATEIDX: begin
        step    = 1'b1;
        state_d = (MAC_ITER_W'(iter_nxt) == cfg_q.nb_iter) ? FSM_TERMINATE : FSM_START;
      end
      FSM_TERMINATE: state_d = FSM_IDLE;
      default:       state_d = FSM_IDLE;
    endcase
    // soft clear overrides everything in this cycle
    if (clear_i) begin
      state_d = FSM_IDLE;
      load    = 1'b0;
      step    = 1'b0;
      req     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= FSM_IDLE;
      cfg_q       <= '0;
      first_q     <= 1'b0;
      sink_seen_q <= 1'b0;
      zero_done_q <= 1'b0;
    end else if (clear_i) begin
      state_q     <= FSM_IDLE;
      cfg_q       <= '0;
      first_q     <= 1'b0;
      sink_seen_q <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (load) begin
        cfg_q <= '{nb_iter:    MAC_ITER_W'(nb_iter_i),
                   len:        MAC_LEN_W'(len_iter_i),
                   shift:      shift_i,
                   simple_mul: simple_mul_i};
      end
      zero_done_q <= load && zero_job;
      first_q     <= (state_d == FSM_START) && (state_q != FSM_START);
      if (state_d == FSM_UPDATEIDX)
        sink_seen_q <= 1'b0;
      else if (state_q == FSM_COMPUTE && sink_done_i)
        sink_seen_q <= 1'b1;
    end
  end

  mac_iter_addrgen #(.NB_ITER_W(NB_ITER_W)) u_addrgen (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (clear_i),
    .load_i     (load),
    .step_i     (step),
    .base_a_i   (base_a_i),
    .base_b_i   (base_b_i),
    .base_c_i   (base_c_i),
    .base_d_i   (base_d_i),
    .stride_i   (stride_i),
    .addr_a_o   (addr_a_o),
    .addr_b_o   (addr_b_o),
    .addr_c_o   (addr_c_o),
    .addr_d_o   (addr_d_o),
    .iter_cnt_o (iter_cnt)
  );

  assign src_req_o  = req;
  assign busy_o     = (state_q != FSM_IDLE);
  assign done_o     = zero_done_q || (state_q == FSM_TERMINATE);
  assign state_o    = state_q;

  always_comb begin
    ctrl_engine_o            = '0;
    ctrl_engine_o.clear      = eng_clear;
    ctrl_engine_o.enable     = busy_o;
    ctrl_engine_o.start      = req;
    ctrl_engine_o.simple_mul = cfg_q.simple_mul;
    ctrl_engine_o.shift      = cfg_q.shift;
    ctrl_engine_o.len        = cfg_q.len;
  end

endmodule

// File: tb/tb_mac_iter_sequencer.sv
// Directed bench for mac_iter_sequencer. A responder answers each src_req_o
// with acc_done and sink_done; a monitor logs request addresses and counts
// done pulses, clear cycles and FSM_WAIT cycles.
module tb_mac_iter_sequencer;
  import mac_package::*;

  logic          clk_i = 1'b0;
  logic          rst_i, clear_i, start_i, simple_mul_i, src_ready_i, sink_done_i;
  logic [15:0]   nb_iter_i;
  logic [10:0]   len_iter_i;
  logic [4:0]    shift_i;
  logic [31:0]   base_a_i, base_b_i, base_c_i, base_d_i, stride_i;
  logic          src_req_o, busy_o, done_o;
  logic [31:0]   addr_a_o, addr_b_o, addr_c_o, addr_d_o;
  ctrl_engine_t  ctrl_engine_o;
  flags_engine_t flags_engine_i;
  state_fsm_t    state_o;

  mac_iter_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .nb_iter_i(nb_iter_i), .len_iter_i(len_iter_i), .shift_i(shift_i),
    .simple_mul_i(simple_mul_i), .base_a_i(base_a_i), .base_b_i(base_b_i),
    .base_c_i(base_c_i), .base_d_i(base_d_i), .stride_i(stride_i),
    .src_ready_i(src_ready_i), .src_req_o(src_req_o), .addr_a_o(addr_a_o),
    .addr_b_o(addr_b_o), .addr_c_o(addr_c_o), .addr_d_o(addr_d_o),
    .ctrl_engine_o(ctrl_engine_o), .flags_engine_i(flags_engine_i),
    .sink_done_i(sink_done_i), .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_fail = 0;
  int req_cnt = 0, done_cnt = 0, clr_cnt = 0, wait_cnt = 0;
  logic [31:0] log_a [0:63];
  logic [31:0] log_d [0:63];
  bit resp_coinc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (src_req_o) begin
      log_a[req_cnt[5:0]] <= addr_a_o;
      log_d[req_cnt[5:0]] <= addr_d_o;
      req_cnt <= req_cnt + 1;
    end
    if (done_o) done_cnt <= done_cnt + 1;
    if (ctrl_engine_o.clear) clr_cnt <= clr_cnt + 1;
    if (state_o == FSM_WAIT) wait_cnt <= wait_cnt + 1;
  end

  // engine/sink model: acc_done 2 cycles after the request, sink_done either
  // in the same cycle or one cycle after acc_done drops
  initial begin
    flags_engine_i.acc_done = 1'b0;
    sink_done_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (src_req_o) begin
        repeat (2) @(negedge clk_i);
        flags_engine_i.acc_done = 1'b1;
        if (resp_coinc) sink_done_i = 1'b1;
        @(negedge clk_i);
        flags_engine_i.acc_done = 1'b0;
        sink_done_i = 1'b0;
        if (!resp_coinc) begin
          @(negedge clk_i);
          sink_done_i = 1'b1;
          @(negedge clk_i);
          sink_done_i = 1'b0;
        end
      end
    end
  end

  task automatic set_cfg(input logic [15:0] nb, input logic [10:0] len,
                         input logic [31:0] ba, input logic [31:0] bd, input logic [31:0] st);
    nb_iter_i = nb; len_iter_i = len; base_a_i = ba; base_b_i = ba + 32'h8000;
    base_c_i = bd - 32'h100; base_d_i = bd; stride_i = st;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (done_o) ok = 1;
      else @(negedge clk_i);
    end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic mid_job_kill(input bit use_rst);
    int n, r0, d0;
    bit hit, ok;
    set_cfg(16'd3, 11'd8, 32'h0000_0500, 32'h0000_0900, 32'h10);
    pulse_start();
    n = 0; hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk_i);
      if (src_req_o) n++;
      if (n == 2 && state_o == FSM_COMPUTE) hit = 1;
    end
    chk("kill_reach_compute2", 32'(hit), 32'd1);
    d0 = done_cnt;
    if (use_rst) begin
      rst_i = 1'b1; #1;
    end else begin
      clear_i = 1'b1; @(negedge clk_i);
    end
    chk("kill_state", 32'(state_o), 32'(FSM_IDLE));
    chk("kill_busy", 32'(busy_o), 32'd0);
    chk("kill_addr_a", addr_a_o, 32'd0);
    chk("kill_addr_d", addr_d_o, 32'd0);
    chk("kill_ctrl", 32'(ctrl_engine_o), 32'd0);
    chk("kill_req", 32'(src_req_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0; clear_i = 1'b0;
    repeat (8) @(negedge clk_i);
    chk("kill_no_done", 32'(done_cnt - d0), 32'd0);
    chk("kill_idle", 32'(state_o), 32'(FSM_IDLE));
    // a fresh job afterwards must run normally
    r0 = req_cnt; d0 = done_cnt;
    set_cfg(16'd2, 11'd4, 32'h0000_1000, 32'h0000_3000, 32'h10);
    pulse_start();
    wait_done(ok);
    chk("rerun_done_seen", 32'(ok), 32'd1);
    chk("rerun_reqs", 32'(req_cnt - r0), 32'd2);
    chk("rerun_dones", 32'(done_cnt - d0), 32'd1);
    chk("rerun_a0", log_a[r0], 32'h0000_1000);
    chk("rerun_a1", log_a[r0+1], 32'h0000_1010);
    chk("rerun_d1", log_d[r0+1], 32'h0000_3004);
  endtask

  initial begin
    int r0, d0, w0, c0;
    bit ok, bad;
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; simple_mul_i = 1'b0;
    src_ready_i = 1'b1; shift_i = '0;
    set_cfg(16'd0, 11'd0, 32'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clk_i);
    chk("rst_state", 32'(state_o), 32'(FSM_IDLE));
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_req", 32'(src_req_o), 32'd0);
    chk("rst_addr_a", addr_a_o, 32'd0);
    chk("rst_ctrl", 32'(ctrl_engine_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // basic 3-iteration job
    r0 = req_cnt; d0 = done_cnt; w0 = wait_cnt;
    set_cfg(16'd3, 11'd8, 32'h0000_0100, 32'h0000_0400, 32'd32);
    shift_i = 5'd2; simple_mul_i = 1'b1;
    pulse_start();
    chk("a_state_start", 32'(state_o), 32'(FSM_START));
    chk("a_clear_first", 32'(ctrl_engine_o.clear), 32'd1);
    chk("a_busy", 32'(busy_o), 32'd1);
    chk("a_len", 32'(ctrl_engine_o.len), 32'd8);
    chk("a_shift", 32'(ctrl_engine_o.shift), 32'd2);
    chk("a_smul", 32'(ctrl_engine_o.simple_mul), 32'd1);
    shift_i = 5'd0; simple_mul_i = 1'b0;
    @(negedge clk_i);
    chk("a_shift_held", 32'(ctrl_engine_o.shift), 32'd2);
    wait_done(ok);
    chk("a_done_seen", 32'(ok), 32'd1);
    chk("a_reqs", 32'(req_cnt - r0), 32'd3);
    chk("a_dones", 32'(done_cnt - d0), 32'd1);
    chk("a_addr0", log_a[r0], 32'h0000_0100);
    chk("a_addr1", log_a[r0+1], 32'h0000_0120);
    chk("a_addr2", log_a[r0+2], 32'h0000_0140);
    chk("a_addrd0", log_d[r0], 32'h0000_0400);
    chk("a_addrd2", log_d[r0+2], 32'h0000_0408);
    chk("a_wait_cycles", 32'(wait_cnt - w0), 32'd6);
    chk("a_idle_after", 32'(busy_o), 32'd0);

    // empty jobs: nb_iter == 0, then len == 0
    r0 = req_cnt; d0 = done_cnt;
    set_cfg(16'd0, 11'd8, 32'h0000_0100, 32'h0000_0400, 32'd32);
    pulse_start();
    chk("z_done_nb0", 32'(done_o), 32'd1);
    chk("z_busy_nb0", 32'(busy_o), 32'd0);
    chk("z_state_nb0", 32'(state_o), 32'(FSM_IDLE));
    @(negedge clk_i);
    chk("z_done_once", 32'(done_o), 32'd0);
    set_cfg(16'd2, 11'd0, 32'h0000_0100, 32'h0000_0400, 32'd32);
    pulse_start();
    chk("z_done_len0", 32'(done_o), 32'd1);
    chk("z_busy_len0", 32'(busy_o), 32'd0);
    repeat (3) @(negedge clk_i);
    chk("z_no_req", 32'(req_cnt - r0), 32'd0);
    chk("z_dones", 32'(done_cnt - d0), 32'd2);

    // src_ready held low: clear only on first START cycle, request on 7th
    r0 = req_cnt; d0 = done_cnt; c0 = clr_cnt;
    src_ready_i = 1'b0;
    set_cfg(16'd1, 11'd16, 32'h0000_0800, 32'h0000_0C00, 32'd64);
    pulse_start();
    chk("c_clear_first", 32'(ctrl_engine_o.clear), 32'd1);
    chk("c_no_req_first", 32'(src_req_o), 32'd0);
    bad = 0;
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk_i);
      if (ctrl_engine_o.clear || src_req_o || state_o != FSM_START) bad = 1;
    end
    chk("c_stall_quiet", 32'(bad), 32'd0);
    @(posedge clk_i); #1;
    src_ready_i = 1'b1;
    @(negedge clk_i);
    chk("c_req_late", 32'(src_req_o), 32'd1);
    chk("c_start_late", 32'(ctrl_engine_o.start), 32'd1);
    chk("c_clear_off", 32'(ctrl_engine_o.clear), 32'd0);
    wait_done(ok);
    chk("c_done_seen", 32'(ok), 32'd1);
    chk("c_clear_count", 32'(clr_cnt - c0), 32'd1);
    chk("c_reqs", 32'(req_cnt - r0), 32'd1);

    // sink_done with acc_done: one-cycle WAIT; second start mid-job ignored
    r0 = req_cnt; d0 = done_cnt; w0 = wait_cnt;
    resp_coinc = 1;
    set_cfg(16'd2, 11'd8, 32'h0000_2000, 32'h0000_4000, 32'h40);
    pulse_start();
    repeat (2) @(negedge clk_i);
    set_cfg(16'd7, 11'd3, 32'hDEAD_0000, 32'h0000_0000, 32'h4);
    pulse_start();
    chk("d_len_stable", 32'(ctrl_engine_o.len), 32'd8);
    wait_done(ok);
    chk("d_done_seen", 32'(ok), 32'd1);
    chk("d_reqs", 32'(req_cnt - r0), 32'd2);
    chk("d_wait_cycles", 32'(wait_cnt - w0), 32'd2);
    chk("d_addr0", log_a[r0], 32'h0000_2000);
    chk("d_addr1", log_a[r0+1], 32'h0000_2040);
    chk("d_dones", 32'(done_cnt - d0), 32'd1);
    resp_coinc = 0;

    mid_job_kill(1'b1);
    mid_job_kill(1'b0);

    // address wrap
    r0 = req_cnt;
    set_cfg(16'd2, 11'd8, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 32'h20);
    pulse_start();
    wait_done(ok);
    chk("f_done_seen", 32'(ok), 32'd1);
    chk("f_addr0", log_a[r0], 32'hFFFF_FFF0);
    chk("f_addr1_wrap", log_a[r0+1], 32'h0000_0010);
    chk("f_addrd1_wrap", log_d[r0+1], 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
